xalu_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its HI/LO registers, sitting in the EX stage beside the main ALU. It accepts a one-cycle start pulse from the EX-stage decode, holds busy for a fixed operation latency, then commits the result to HI/LO. The hazard unit stalls D on `start | busy` when the decode stage holds an HI/LO-touching instruction, so this block never sees overlapping requests in normal flow. Overlapping requests are still defined below.

---
 rtl/xalu_sequencer.sv | 137 +++++++++++++
 tb/tb_xalu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xalu_sequencer.sv
// EX-stage multiply/divide sequencer with HI/LO registers.
// The result is computed and held in pend when a request is accepted; busy then runs a fixed latency before the commit.
module xalu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  xaluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] xalu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        dz;

  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  logic        div_signed;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Low 64 bits of the product of the sign/zero-extended operands give both signed and unsigned results.
  always_comb begin
    mul_signed = (xaluop == OP_MULT);
    mul_a      = {(mul_signed ? {32{a[31]}} : 32'h0), a};
    mul_b      = {(mul_signed ? {32{b[31]}} : 32'h0), b};
    prod       = mul_a * mul_b;
  end

  // Signed divide works on magnitudes, so 0x80000000 / -1 naturally wraps to 0x80000000.
  always_comb begin
    div_signed = (xaluop == OP_DIV);
    num        = (div_signed && a[31]) ? (32'h0 - a) : a;
    den        = (div_signed && b[31]) ? (32'h0 - b) : b;
    den_safe   = (den == 32'h0) ? 32'h1 : den;
    q_mag      = num / den_safe;
    r_mag      = num % den_safe;
    quo        = (div_signed && (a[31] ^ b[31])) ? (32'h0 - q_mag) : q_mag;
    rem        = (div_signed && a[31]) ? (32'h0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          case (xaluop)
            OP_MULT, OP_MULTU: begin
              if (start) begin
                pend  <= prod;
                dz    <= 1'b0;
                cnt   <= MULT_LOAD;
                state <= S_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              if (start) begin
                if (b == 32'h0) begin
                  dz <= 1'b1;
                end else begin
                  dz   <= 1'b0;
                  pend <= {rem, quo};
                end
                cnt   <= DIV_LOAD;
                state <= S_DIV;
              end
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
          endcase
        end
        S_MUL, S_DIV: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    case (xaluop)
      OP_MFHI: xalu_out = hi;
      OP_MFLO: xalu_out = lo;
      default: xalu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_xalu_sequencer.sv
// Bench for xalu_sequencer: a cycle-level reference model (remaining-latency counter plus
// arithmetic results) checked every cycle, plus directed cases with hand-computed results.
module tb_xalu_sequencer;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  xaluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] xalu_out;

  int n_checks = 0;
  int n_fail   = 0;

  xalu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .xaluop(xaluop), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .xalu_out(xalu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles of latency left, architectural HI/LO, pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          m_dz = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_dz = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else begin
      if (start && (xaluop == MULT || xaluop == MULTU)) begin
        longint p;
        if (xaluop == MULT) p = longint'(int'(a)) * longint'(int'(b));
        else                p = longint'({32'h0, a} * {32'h0, b});
        p_hi = p[63:32];
        p_lo = p[31:0];
        m_dz = 0;
        m_left = MC;
      end else if (start && (xaluop == DIV || xaluop == DIVU)) begin
        m_left = DC;
        if (b == 0) begin
          m_dz = 1;
        end else begin
          m_dz = 0;
          if (xaluop == DIVU) begin
            p_lo = a / b;
            p_hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000;
            p_hi = 0;
          end else begin
            int q, r;
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            p_lo = q;
            p_hi = r;
          end
        end
      end else if (xaluop == MTHI) begin
        m_hi = a;
      end else if (xaluop == MTLO) begin
        m_lo = a;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] exp_out;
      exp_out = (xaluop == MFHI) ? m_hi : (xaluop == MFLO) ? m_lo : 32'h0;
      chk("busy", {31'h0, busy}, {31'h0, m_left > 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("xalu_out", xalu_out, exp_out);
    end
  end

  task automatic set_in(input bit s, input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    start = s; xaluop = op; a = aa; b = bb;
  endtask

  task automatic cyc(input bit s, input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk); #2;
    set_in(s, op, aa, bb);
  endtask

  // Returns in the first idle cycle (inputs already NOP, caller may override before the edge).
  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      set_in(0, NOP, $urandom, $urandom);
      if (!busy) return;
      nb++;
    end
    chk("busy_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input int exp_n, input logic [31:0] eh, input logic [31:0] el);
    int nb;
    cyc(1, op, aa, bb);
    #1 chk({nm, "_busy_at_start"}, {31'h0, busy}, 32'h0);
    wait_done(nb);
    chk({nm, "_cycles"}, 32'(nb), 32'(exp_n));
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    reset = 1'b0;
    set_in(0, NOP, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    #2 reset = 1'b1;
    chk_en = 1;

    run_op("mult_neg", MULT,  32'hFFFF_FFFF, 32'd2, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",    MULTU, 32'hFFFF_FFFF, 32'd2, MC, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg",  DIV,   32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",     DIVU,  32'd7,         32'd2, DC, 32'd1,         32'd3);
    run_op("div_ovf",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000);

    cyc(1, MTHI, 32'h11, 0);
    cyc(0, MTLO, 32'h22, 0);
    run_op("div_zero", DIV, 32'd5, 32'd0, DC, 32'h11, 32'h22);

    // Requests while busy are dropped; MFLO still sees the old LO.
    cyc(0, MTLO, 32'h55, 0);
    cyc(0, MTHI, 32'h66, 0);
    cyc(1, MULT, 32'd7, 32'd6);
    cyc(0, MTHI, 32'hDEAD, 0);
    cyc(1, MULT, 32'd9, 32'd9);
    cyc(0, MFLO, 0, 0);
    #1 chk("mflo_busy", xalu_out, 32'h55);
    wait_done(nb);
    chk("busy_ign_cycles", 32'(nb), 32'(MC - 3));
    chk("busy_ign_hi", hi, 32'h0);
    chk("busy_ign_lo", lo, 32'd42);

    cyc(1, MULT, 32'd2, 32'd3);
    wait_done(nb);
    chk("b2b_first_lo", lo, 32'd6);
    set_in(1, MULT, 32'd4, 32'd5);
    wait_done(nb);
    chk("b2b_cycles", 32'(nb), 32'(MC));
    chk("b2b_second_lo", lo, 32'd20);

    // Asynchronous reset in the fourth busy cycle of a divide.
    cyc(0, MTHI, 32'h77, 0);
    cyc(1, DIV, 32'd100, 32'd7);
    repeat (3) cyc(0, NOP, 0, 0);
    cyc(0, NOP, 0, 0);
    #1 reset = 1'b0;
    #1 chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(negedge clk); #2 reset = 1'b1;
    run_op("mult_after_rst", MULT, 32'd3, 32'd4, MC, 32'h0, 32'd12);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  op;
      int          sel;
      op  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(1, 4));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'h0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      cyc(($urandom_range(0, 3) != 0), op, ra, rb);
    end
    cyc(0, NOP, 0, 0);
    wait_done(nb);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
